// File: rtl/qrr_arb_if.sv
// rtl/qrr_arb_if.sv - dti queue channel: one beat of W bits with valid/ready handshake
interface qrr_arb_if #(
    parameter int W = 8
);
    logic         valid;
    logic         ready;
    logic [W-1:0] data;

    // Side that drives beats into the channel
    modport producer (
        output valid,
        output data,
        input  ready
    );

    // Side that takes beats out of the channel
    modport consumer (
        input  valid,
        input  data,
        output ready
    );
endinterface

// File: rtl/qrr_arb.sv
// rtl/qrr_arb.sv - round-robin transaction-locked arbiter merging NUM dti queues into one tagged queue
module qrr_arb #(
    parameter int NUM    = 2,
    parameter int W_DIN  = 16,
    parameter int LVL    = 1,
    parameter int W_CTRL = $clog2(NUM)
) (
    input  logic        clk,
    input  logic        rst,
    qrr_arb_if.consumer din [NUM],
    qrr_arb_if.producer dout
);
    localparam int W_IN  = LVL + W_DIN;
    localparam int W_OUT = LVL + W_CTRL + W_DIN;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } st_t;

    st_t              st, st_nxt;
    logic [W_CTRL-1:0] gnt, gnt_nxt;
    logic [W_CTRL-1:0] ptr, ptr_nxt;
    logic [W_OUT-1:0]  out_reg, out_reg_nxt;
    logic              out_valid, out_valid_nxt;

    logic [NUM-1:0]    in_valid;
    logic [W_IN-1:0]   in_beat [NUM];
    logic [NUM-1:0]    rdy;

    logic [W_CTRL-1:0] cand;
    logic              cand_ok;
    logic              sel_valid;
    logic [W_IN-1:0]   sel_beat;
    logic              can_load;
    logic              accept;
    logic              last;

    // Flatten the interface array so the arbitration logic can index it with loops
    for (genvar g = 0; g < NUM; g++) begin : g_in
        assign in_valid[g]  = din[g].valid;
        assign in_beat[g]   = din[g].data;
        assign din[g].ready = rdy[g];
        assign rdy[g]       = can_load && cand_ok && (cand == W_CTRL'(g));
    end

    // Output stage is a pure register; valid and data never see combinational paths
    assign dout.valid = out_valid;
    assign dout.data  = out_reg;

    // Slot is free when empty or being drained this cycle; held off entirely during reset
    assign can_load = rst && (!out_valid || dout.ready);

    // Candidate: locked source, or first valid input after ptr in wrap-around order
    always_comb begin
        cand    = gnt;
        cand_ok = 1'b0;
        if (st == LOCKED) begin
            cand    = gnt;
            cand_ok = 1'b1;
        end else begin
            // Descending distance so the nearest valid input after ptr is written last
            for (int k = NUM; k >= 1; k--) begin
                for (int i = 0; i < NUM; i++) begin
                    if (in_valid[i] && ((int'(ptr) + k) % NUM == i)) begin
                        cand    = W_CTRL'(i);
                        cand_ok = 1'b1;
                    end
                end
            end
        end
    end

    // Route the candidate's valid and beat to the load path
    always_comb begin
        sel_valid = 1'b0;
        sel_beat  = '0;
        for (int i = 0; i < NUM; i++) begin
            if (cand == W_CTRL'(i)) begin
                sel_valid = in_valid[i];
                sel_beat  = in_beat[i];
            end
        end
    end

    assign accept = cand_ok && can_load && sel_valid;
    assign last   = &sel_beat[W_IN-1 -: LVL];

    // Next-state: lock on a non-final beat, release and advance ptr on the final beat
    always_comb begin
        st_nxt        = st;
        gnt_nxt       = gnt;
        ptr_nxt       = ptr;
        out_reg_nxt   = out_reg;
        out_valid_nxt = out_valid;
        if (accept) begin
            out_reg_nxt   = {sel_beat[W_IN-1 -: LVL], cand, sel_beat[W_DIN-1:0]};
            out_valid_nxt = 1'b1;
            if (last) begin
                st_nxt  = IDLE;
                ptr_nxt = cand;
            end else begin
                st_nxt  = LOCKED;
                gnt_nxt = cand;
            end
        end else if (out_valid && dout.ready) begin
            out_valid_nxt = 1'b0;
        end
    end

    // State register; reset drops any in-flight transaction
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st        <= IDLE;
            gnt       <= '0;
            ptr       <= W_CTRL'(NUM - 1);
            out_reg   <= '0;
            out_valid <= 1'b0;
        end else begin
            st        <= st_nxt;
            gnt       <= gnt_nxt;
            ptr       <= ptr_nxt;
            out_reg   <= out_reg_nxt;
            out_valid <= out_valid_nxt;
        end
    end
endmodule

// File: tb/tb_qrr_arb.sv
// tb/tb_qrr_arb.sv - directed self-checking bench for qrr_arb
module tb_qrr_arb;
    logic clk;
    logic rst;
    int   passed;
    int   total;

    // Main instance: NUM=3, W_DIN=8, LVL=1 -> out {eot, ctrl[1:0], data[7:0]}
    qrr_arb_if #(.W(9))  din_a [3] ();
    qrr_arb_if #(.W(11)) dout_a ();
    // Level-2 instance: NUM=2, W_DIN=8, LVL=2 -> out {eot[1:0], ctrl, data[7:0]}
    qrr_arb_if #(.W(10)) din_b [2] ();
    qrr_arb_if #(.W(11)) dout_b ();

    logic [2:0] rdy_a;
    logic [1:0] rdy_b;
    assign rdy_a = {din_a[2].ready, din_a[1].ready, din_a[0].ready};
    assign rdy_b = {din_b[1].ready, din_b[0].ready};

    qrr_arb #(.NUM(3), .W_DIN(8), .LVL(1)) u_a (
        .clk (clk),
        .rst (rst),
        .din (din_a),
        .dout(dout_a)
    );

    qrr_arb #(.NUM(2), .W_DIN(8), .LVL(2)) u_b (
        .clk (clk),
        .rst (rst),
        .din (din_b),
        .dout(dout_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic set_a(input int i, input logic v, input logic e, input logic [7:0] d);
        case (i)
            0: begin din_a[0].valid = v; din_a[0].data = {e, d}; end
            1: begin din_a[1].valid = v; din_a[1].data = {e, d}; end
            default: begin din_a[2].valid = v; din_a[2].data = {e, d}; end
        endcase
    endtask

    task automatic set_b(input int i, input logic v, input logic [1:0] e, input logic [7:0] d);
        case (i)
            0: begin din_b[0].valid = v; din_b[0].data = {e, d}; end
            default: begin din_b[1].valid = v; din_b[1].data = {e, d}; end
        endcase
    endtask

    logic [10:0] rr_data [4];
    logic [2:0]  rr_rdy  [4];

    initial begin
        passed = 0;
        total  = 0;
        rst    = 1'b0;
        dout_a.ready = 1'b1;
        dout_b.ready = 1'b1;
        for (int i = 0; i < 3; i++) set_a(i, 1'b1, 1'b1, 8'hA0 + 8'(i));
        set_b(0, 1'b0, 2'b00, 8'h00);
        set_b(1, 1'b0, 2'b00, 8'h00);

        // Reset state: no output, no readies even with every input valid
        #1;
        chk("rst_valid_a", dout_a.valid, 0);
        chk("rst_data_a", dout_a.data, 0);
        chk("rst_rdy_a", rdy_a, 3'b000);
        chk("rst_valid_b", dout_b.valid, 0);
        cyc();
        cyc();
        rst = 1'b1;
        #1;
        chk("rr_first_rdy", rdy_a, 3'b001);
        chk("rr_first_valid", dout_a.valid, 0);

        // Single-beat round robin, ptr starts at NUM-1 so input 0 wins first
        rr_data = '{11'h4A0, 11'h5A1, 11'h6A2, 11'h4A0};
        rr_rdy  = '{3'b010, 3'b100, 3'b001, 3'b010};
        for (int n = 0; n < 4; n++) begin
            cyc();
            chk("rr_valid", dout_a.valid, 1);
            chk("rr_data", dout_a.data, rr_data[n]);
            chk("rr_rdy", rdy_a, rr_rdy[n]);
        end
        for (int i = 0; i < 3; i++) set_a(i, 1'b0, 1'b0, 8'h00);
        cyc();
        chk("rr_drain", dout_a.valid, 0);

        // Lock hold: input 1 four-beat queue, input 2 must wait
        set_a(1, 1'b1, 1'b0, 8'h10);
        set_a(2, 1'b1, 1'b1, 8'h20);
        #1;
        chk("lock_rdy0", rdy_a, 3'b010);
        for (int n = 1; n < 4; n++) begin
            cyc();
            chk("lock_data", dout_a.data, 11'h100 + 11'(n) + 11'h0F);
            set_a(1, 1'b1, (n == 3), 8'h10 + 8'(n));
            #1;
            chk("lock_rdy", rdy_a, 3'b010);
        end
        cyc();
        chk("lock_last", dout_a.data, 11'h513);
        set_a(1, 1'b0, 1'b0, 8'h00);
        #1;
        chk("lock_next_rdy", rdy_a, 3'b100);
        cyc();
        chk("lock_next_data", dout_a.data, 11'h620);
        set_a(2, 1'b0, 1'b0, 8'h00);
        cyc();
        chk("lock_drain", dout_a.valid, 0);

        // Back-pressure mid-queue on input 0
        set_a(0, 1'b1, 1'b0, 8'h30);
        #1;
        chk("bp_rdy0", rdy_a, 3'b001);
        cyc();
        chk("bp_d0", dout_a.data, 11'h030);
        set_a(0, 1'b1, 1'b0, 8'h31);
        #1;
        chk("bp_rdy1", rdy_a, 3'b001);
        cyc();
        chk("bp_d1", dout_a.data, 11'h031);
        dout_a.ready = 1'b0;
        set_a(0, 1'b1, 1'b1, 8'h32);
        #1;
        chk("bp_stall_rdy", rdy_a, 3'b000);
        for (int n = 0; n < 4; n++) begin
            cyc();
            chk("bp_hold_data", dout_a.data, 11'h031);
            chk("bp_hold_valid", dout_a.valid, 1);
            chk("bp_hold_rdy", rdy_a, 3'b000);
        end
        cyc();
        chk("bp_hold_data5", dout_a.data, 11'h031);
        dout_a.ready = 1'b1;
        #1;
        chk("bp_release_rdy", rdy_a, 3'b001);
        cyc();
        chk("bp_d2", dout_a.data, 11'h432);
        set_a(0, 1'b0, 1'b0, 8'h00);
        cyc();
        chk("bp_drain", dout_a.valid, 0);

        // Bubbles inside a lock on input 0 while input 2 waits
        set_a(0, 1'b1, 1'b0, 8'h40);
        #1;
        chk("bub_rdy0", rdy_a, 3'b001);
        cyc();
        chk("bub_d0", dout_a.data, 11'h040);
        set_a(0, 1'b0, 1'b0, 8'h40);
        set_a(2, 1'b1, 1'b1, 8'h50);
        #1;
        chk("bub_rdy_lock", rdy_a, 3'b001);
        for (int n = 0; n < 3; n++) begin
            cyc();
            chk("bub_gap_valid", dout_a.valid, 0);
            chk("bub_gap_rdy", rdy_a, 3'b001);
        end
        set_a(0, 1'b1, 1'b1, 8'h41);
        #1;
        chk("bub_resume_rdy", rdy_a, 3'b001);
        cyc();
        chk("bub_d1", dout_a.data, 11'h441);
        set_a(0, 1'b0, 1'b0, 8'h00);
        #1;
        chk("bub_next_rdy", rdy_a, 3'b100);
        cyc();
        chk("bub_next_data", dout_a.data, 11'h650);
        set_a(2, 1'b0, 1'b0, 8'h00);
        cyc();
        chk("bub_drain", dout_a.valid, 0);

        // Asynchronous reset while locked on input 2
        set_a(2, 1'b1, 1'b0, 8'h60);
        #1;
        chk("ar_rdy0", rdy_a, 3'b100);
        cyc();
        chk("ar_d0", dout_a.data, 11'h260);
        set_a(0, 1'b1, 1'b1, 8'hA0);
        set_a(1, 1'b1, 1'b1, 8'hA1);
        set_a(2, 1'b1, 1'b0, 8'h61);
        #1;
        chk("ar_locked_rdy", rdy_a, 3'b100);
        rst = 1'b0;
        #1;
        chk("ar_valid_drop", dout_a.valid, 0);
        chk("ar_rdy_drop", rdy_a, 3'b000);
        cyc();
        rst = 1'b1;
        #1;
        chk("ar_post_rdy", rdy_a, 3'b001);
        chk("ar_post_valid", dout_a.valid, 0);
        cyc();
        chk("ar_post_data", dout_a.data, 11'h4A0);
        chk("ar_post_rdy2", rdy_a, 3'b010);
        for (int i = 0; i < 3; i++) set_a(i, 1'b0, 1'b0, 8'h00);
        cyc();
        chk("ar_drain", dout_a.valid, 0);

        // LVL=2: only eot=2'b11 ends the transaction; eot copied unchanged
        set_b(0, 1'b1, 2'b10, 8'h70);
        set_b(1, 1'b1, 2'b11, 8'h80);
        #1;
        chk("l2_rdy0", rdy_b, 2'b01);
        cyc();
        chk("l2_d0", dout_b.data, 11'h470);
        set_b(0, 1'b1, 2'b01, 8'h71);
        #1;
        chk("l2_rdy1", rdy_b, 2'b01);
        cyc();
        chk("l2_d1", dout_b.data, 11'h271);
        set_b(0, 1'b1, 2'b11, 8'h72);
        #1;
        chk("l2_rdy2", rdy_b, 2'b01);
        cyc();
        chk("l2_d2", dout_b.data, 11'h672);
        set_b(0, 1'b0, 2'b00, 8'h00);
        #1;
        chk("l2_next_rdy", rdy_b, 2'b10);
        cyc();
        chk("l2_next_data", dout_b.data, 11'h780);
        set_b(1, 1'b0, 2'b00, 8'h00);
        cyc();
        chk("l2_drain", dout_b.valid, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
